// File: rtl/rv32_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv32_mem_pkg
// Brief    : Shared types and default widths for the unified dual-port memory.
// Revision : 1.0 - initial release
// ============================================================================
package rv32_mem_pkg;

  localparam int MEM_ADDR_W = 16;
  localparam int MEM_DATA_W = 32;
  localparam int MEM_NB_COL = 4;

  typedef enum logic [0:0] {
    PRIO_CORE = 1'b0,
    PRIO_DMA  = 1'b1
  } arb_state_t;

  typedef enum logic [0:0] {
    REQ_CORE = 1'b0,
    REQ_DMA  = 1'b1
  } req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } rsp_tag_t;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Core/DMA arbiter for RAM port B with starvation guard and
//            read-response routing.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import rv32_mem_pkg::*;
#(
  parameter int ADDR_W       = MEM_ADDR_W,
  parameter int DATA_W       = MEM_DATA_W,
  parameter int NB_COL       = MEM_NB_COL,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              core_req_i,
  input  logic [NB_COL-1:0] core_we_i,
  input  logic [ADDR_W-1:0] core_addr_i,
  input  logic [DATA_W-1:0] core_wdata_i,
  output logic              core_gnt_o,
  output logic              core_rvalid_o,
  output logic [DATA_W-1:0] core_rdata_o,
  input  logic              dma_req_i,
  input  logic [NB_COL-1:0] dma_we_i,
  input  logic [ADDR_W-1:0] dma_addr_i,
  input  logic [DATA_W-1:0] dma_wdata_i,
  output logic              dma_gnt_o,
  output logic              dma_rvalid_o,
  output logic [DATA_W-1:0] dma_rdata_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [NB_COL-1:0] mem_we_o,
  output logic [DATA_W-1:0] mem_din_o,
  input  logic [DATA_W-1:0] mem_dout_i
);

  // A zero limit still needs a 1-bit counter; it simply never moves.
  localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(STARVE_LIMIT);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  rsp_tag_t         tag_q, tag_d;
  logic             core_gnt, dma_gnt;

  always_comb begin
    core_gnt = 1'b0;
    dma_gnt  = 1'b0;
    if (!rst_i) begin
      if (state_q == PRIO_DMA && dma_req_i) dma_gnt = 1'b1;
      else if (core_req_i)                  core_gnt = 1'b1;
      else if (dma_req_i)                   dma_gnt = 1'b1;
    end
  end

  always_comb begin
    mem_addr_o = core_addr_i;
    mem_din_o  = core_wdata_i;
    mem_we_o   = '0;
    if (dma_gnt) begin
      mem_addr_o = dma_addr_i;
      mem_din_o  = dma_wdata_i;
      mem_we_o   = dma_we_i;
    end else if (core_gnt) begin
      mem_we_o   = core_we_i;
    end
  end

  always_comb begin
    starve_d = starve_q;
    state_d  = state_q;
    if (!dma_req_i || dma_gnt) begin
      starve_d = '0;
    end else if (state_q == PRIO_CORE && core_gnt && starve_q != C_LIMIT) begin
      starve_d = starve_q + 1'b1;
    end

    if (state_q == PRIO_DMA) begin
      if (dma_gnt || !dma_req_i) state_d = PRIO_CORE;
    end else if (STARVE_LIMIT != 0 && starve_d == C_LIMIT) begin
      state_d = PRIO_DMA;
    end

    tag_d.valid = (core_gnt && core_we_i == '0) || (dma_gnt && dma_we_i == '0);
    tag_d.id    = dma_gnt ? REQ_DMA : REQ_CORE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= PRIO_CORE;
      starve_q <= '0;
      tag_q    <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      tag_q    <= tag_d;
    end
  end

  // A read granted just before reset still has its tag set during the first
  // reset cycle; gating with rst_i suppresses that stale response.
  assign core_gnt_o    = core_gnt;
  assign dma_gnt_o     = dma_gnt;
  assign core_rvalid_o = !rst_i && tag_q.valid && tag_q.id == REQ_CORE;
  assign dma_rvalid_o  = !rst_i && tag_q.valid && tag_q.id == REQ_DMA;
  assign core_rdata_o  = mem_dout_i;
  assign dma_rdata_o   = mem_dout_i;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Directed self-checking bench for mem_port_arbiter (limits 3 and 8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req, dma_req;
  logic [3:0]  core_we, dma_we;
  logic [15:0] core_addr, dma_addr;
  logic [31:0] core_wdata, dma_wdata;

  logic        c_gnt, c_rv, d_gnt, d_rv;
  logic [31:0] c_rd, d_rd, m_din, m_dout;
  logic [15:0] m_addr;
  logic [3:0]  m_we;

  logic        c_gnt8, c_rv8, d_gnt8, d_rv8;
  logic [31:0] c_rd8, d_rd8, m_din8;
  logic [15:0] m_addr8;
  logic [3:0]  m_we8;

  logic [31:0] ram [0:255];
  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_LIMIT(3)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .core_req_i(core_req), .core_we_i(core_we), .core_addr_i(core_addr),
    .core_wdata_i(core_wdata), .core_gnt_o(c_gnt), .core_rvalid_o(c_rv),
    .core_rdata_o(c_rd),
    .dma_req_i(dma_req), .dma_we_i(dma_we), .dma_addr_i(dma_addr),
    .dma_wdata_i(dma_wdata), .dma_gnt_o(d_gnt), .dma_rvalid_o(d_rv),
    .dma_rdata_o(d_rd),
    .mem_addr_o(m_addr), .mem_we_o(m_we), .mem_din_o(m_din), .mem_dout_i(m_dout)
  );

  mem_port_arbiter #(.STARVE_LIMIT(8)) u_dut8 (
    .clk_i(clk), .rst_i(rst),
    .core_req_i(core_req), .core_we_i(core_we), .core_addr_i(core_addr),
    .core_wdata_i(core_wdata), .core_gnt_o(c_gnt8), .core_rvalid_o(c_rv8),
    .core_rdata_o(c_rd8),
    .dma_req_i(dma_req), .dma_we_i(dma_we), .dma_addr_i(dma_addr),
    .dma_wdata_i(dma_wdata), .dma_gnt_o(d_gnt8), .dma_rvalid_o(d_rv8),
    .dma_rdata_o(d_rd8),
    .mem_addr_o(m_addr8), .mem_we_o(m_we8), .mem_din_o(m_din8), .mem_dout_i(m_dout)
  );

  // Read-first byte-lane RAM behind the limit-3 instance; preloaded under reset.
  always @(posedge clk) begin
    if (rst) begin
      ram[8'h10] <= 32'hDEADBEEF;
      ram[8'h20] <= 32'h11111111;
      ram[8'h21] <= 32'h22222222;
      ram[8'h30] <= 32'h12345678;
    end else begin
      for (int b = 0; b < 4; b++)
        if (m_we[b]) ram[m_addr[7:0]][b*8 +: 8] <= m_din[b*8 +: 8];
    end
    m_dout <= ram[m_addr[7:0]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    core_req = 1'b0; core_we = 4'h0; core_addr = 16'h0; core_wdata = 32'h0;
    dma_req  = 1'b0; dma_we  = 4'h0; dma_addr  = 16'h0; dma_wdata  = 32'h0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    step(); step();
    core_req = 1'b1; dma_req = 1'b1; dma_we = 4'hF;
    #1;
    check("rst_core_gnt", {31'b0, c_gnt}, 32'd0);
    check("rst_dma_gnt",  {31'b0, d_gnt}, 32'd0);
    check("rst_mem_we",   {28'b0, m_we},  32'd0);
    check("rst_rvalid",   {30'b0, c_rv, d_rv}, 32'd0);
    idle();
    step();
    rst = 1'b0;

    // Core-only read
    step();
    core_req = 1'b1; core_addr = 16'h0010;
    #1;
    check("core_rd_gnt",  {31'b0, c_gnt}, 32'd1);
    check("core_rd_dgnt", {31'b0, d_gnt}, 32'd0);
    check("core_rd_addr", {16'b0, m_addr}, 32'h0010);
    step();
    core_req = 1'b0;
    check("core_rd_rv",   {31'b0, c_rv}, 32'd1);
    check("core_rd_data", c_rd, 32'hDEADBEEF);
    check("core_rd_drv",  {31'b0, d_rv}, 32'd0);
    step();
    check("core_rv_once", {31'b0, c_rv}, 32'd0);

    // Simultaneous reads: core keeps winning until it drops its request
    core_req = 1'b1; core_addr = 16'h0020;
    dma_req  = 1'b1; dma_addr  = 16'h0021;
    #1;
    check("sim_c0_gnt8", {31'b0, c_gnt8}, 32'd1);
    check("sim_d0_gnt8", {31'b0, d_gnt8}, 32'd0);
    step();
    check("sim_c1_gnt8", {31'b0, c_gnt8}, 32'd1);
    check("sim_d1_gnt8", {31'b0, d_gnt8}, 32'd0);
    check("sim_c_rv",    {31'b0, c_rv}, 32'd1);
    core_req = 1'b0;
    #1;
    check("sim_d2_gnt8", {31'b0, d_gnt8}, 32'd1);
    check("sim_d2_gnt",  {31'b0, d_gnt}, 32'd1);
    step();
    dma_req = 1'b0;
    check("sim_d_rv",    {31'b0, d_rv}, 32'd1);
    check("sim_d_data",  d_rd, 32'h22222222);
    check("sim_c_rv_off", {31'b0, c_rv}, 32'd0);
    step();

    // Starvation: limit 3 gives DMA every 4th cycle, limit 8 on the 9th
    core_req = 1'b1; core_addr = 16'h0020;
    dma_req  = 1'b1; dma_addr  = 16'h0021;
    for (int i = 0; i < 12; i++) begin
      #1;
      check($sformatf("stv3_dgnt_%0d", i), {31'b0, d_gnt}, {31'b0, (i % 4) == 3});
      check($sformatf("stv3_cgnt_%0d", i), {31'b0, c_gnt}, {31'b0, (i % 4) != 3});
      check($sformatf("stv8_dgnt_%0d", i), {31'b0, d_gnt8}, {31'b0, i == 8});
      step();
    end
    idle();
    step();

    // Interleaved core then DMA reads
    core_req = 1'b1; core_addr = 16'h0020;
    #1;
    check("il_c_gnt", {31'b0, c_gnt}, 32'd1);
    step();
    core_req = 1'b0; dma_req = 1'b1; dma_addr = 16'h0021;
    #1;
    check("il_c_rv",   {31'b0, c_rv}, 32'd1);
    check("il_c_data", c_rd, 32'h11111111);
    check("il_d_gnt",  {31'b0, d_gnt}, 32'd1);
    step();
    dma_req = 1'b0;
    check("il_d_rv",   {31'b0, d_rv}, 32'd1);
    check("il_d_data", d_rd, 32'h22222222);
    check("il_c_rv2",  {31'b0, c_rv}, 32'd0);
    step();

    // DMA byte-lane write, then read back
    dma_req = 1'b1; dma_we = 4'b0010; dma_addr = 16'h0030; dma_wdata = 32'h0000AB00;
    #1;
    check("bw_d_gnt", {31'b0, d_gnt}, 32'd1);
    check("bw_we",    {28'b0, m_we}, 32'h2);
    check("bw_din",   m_din, 32'h0000AB00);
    check("bw_addr",  {16'b0, m_addr}, 32'h0030);
    step();
    idle();
    check("bw_no_rv", {30'b0, c_rv, d_rv}, 32'd0);
    core_req = 1'b1; core_addr = 16'h0030;
    step();
    core_req = 1'b0;
    check("bw_rb_rv",   {31'b0, c_rv}, 32'd1);
    check("bw_rb_data", c_rd, 32'h1234AB78);
    step();

    // Reset right after a core read grant, with the counter partly advanced
    core_req = 1'b1; core_addr = 16'h0010; dma_req = 1'b1; dma_addr = 16'h0021;
    step();
    #1;
    check("mr_c_gnt", {31'b0, c_gnt}, 32'd1);
    step();
    rst = 1'b1;
    #1;
    check("mr_no_rv",  {31'b0, c_rv}, 32'd0);
    check("mr_no_gnt", {30'b0, c_gnt, d_gnt}, 32'd0);
    step();
    rst = 1'b0;
    #1;
    check("mr_post_rv", {31'b0, c_rv}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("mr_dgnt_%0d", i), {31'b0, d_gnt}, {31'b0, i == 3});
      check($sformatf("mr_cgnt_%0d", i), {31'b0, c_gnt}, {31'b0, i != 3});
      step();
    end
    idle();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
